cenzor_axil_regs: RTL
=====================

# cenzor_axil_regs

AXI4-Lite responder holding the Cenzor IP's four 32-bit control/data registers. It is the slave end of the S00_AXI port that the master VIP drives with AXI4LITE_WRITE_BURST and AXI4LITE_READ_BURST. It also presents the register contents and per-register write strobes to the Cenzor datapath. Write and read channels are independent state machines with full VALID/READY back-pressure.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width. There are 8 word slots; slots 0–3 are implemented.
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETN  in  1  reset, asynchronous and active-low.
- AWADDR  in  C_S_AXI_ADDR_WIDTH  write address. AWPROT  in  3  ignored. AWVALID  in  1. AWREADY  out  1.
- WDATA  in  32. WSTRB  in  4  byte enables. WVALID  in  1. WREADY  out  1.
- BRESP  out  2. BVALID  out  1. BREADY  in  1.
- ARADDR  in  C_S_AXI_ADDR_WIDTH. ARPROT  in  3  ignored. ARVALID  in  1. ARREADY  out  1.
- RDATA  out  32. RRESP  out  2. RVALID  out  1. RREADY  in  1.
- regs_o  out  128  concatenation {reg3, reg2, reg1, reg0}.
- wr_pulse_o  out  4  one-cycle strobe, bit n set in the cycle after regn is written.

## Operation
- Address decode: word index = ADDR[C_S_AXI_ADDR_WIDTH-1:2]; ADDR[1:0] is ignored.
- Write FSM states:
  - W_IDLE: AWREADY=1 and WREADY=1.
    - AW and W handshake in the same cycle → write performed at that edge, go to W_RESP.
    - AW only → latch the address, go to W_WAITD (AWREADY=0, WREADY=1).
    - W only → latch data and strobe, go to W_WAITA (AWREADY=1, WREADY=0).
  - W_WAITD / W_WAITA: the missing handshake performs the write and moves to W_RESP.
  - W_RESP: BVALID=1. On BREADY → W_IDLE; both READYs are 1 again the next cycle.
- Write merge: byte k of the target register is updated only when WSTRB[k]=1. WSTRB=0 gives a normal response and no change, but wr_pulse_o still fires.
- Read FSM states:
  - R_IDLE: ARREADY=1. On handshake, RDATA and RRESP are registered from the decoded register → R_RESP.
  - R_RESP: RVALID=1, ARREADY=0. RDATA and RRESP stay stable until RREADY → R_IDLE.
- The channels run concurrently. A read and a write to the same register in the same cycle return the old value.
- Reset (asynchronous; also mid-transaction):
  - BVALID=0, RVALID=0, RDATA=0, RRESP=0, BRESP=0, regs_o=0, wr_pulse_o=0.
  - Both FSMs go to their IDLE state and latched address/data are discarded.
  - While ARESETN=0, AWREADY, WREADY and ARREADY are forced to 0. They are 1 from the first edge after release.

## Timing
- Write latency: the last of the AW/W handshakes at edge N → BVALID=1 and wr_pulse_o at N+1, and regs_o updated at N+1.
- Read latency: AR handshake at edge N → RVALID=1 at N+1 with RDATA valid.
- Back-to-back throughput is one write per 2 cycles and one read per 2 cycles when BREADY/RREADY are held at 1.
- VALID outputs never drop without the matching READY.

## Configuration
- CENZOR_AXIL_SLVERR_EN defined: an access to word slots 4–7 returns BRESP or RRESP = SLVERR (2'b10), with RDATA=0. No register changes and no wr_pulse_o fires.
- Not defined: the same accesses return OKAY (2'b00), with RDATA=0 and the write silently dropped.
- Valid slots always return OKAY.

## Structure
- Package cenzor_axil_pkg holds:
  - RESP_OKAY and RESP_SLVERR.
  - NUM_REGS=4.
  - Register index constants REG_CTRL=0, REG_CFG=1, REG_WORD=2, REG_STAT=3.
  - State enums wr_state_t and rd_state_t.
- One sub-module, cenzor_axil_wr_ch: the write FSM with address/data latching. It outputs wr_en, wr_idx and the merged byte strobes. The register array and read FSM stay in the top.

## Test plan
- Sequential writes 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC, then reads of the same addresses → read data 0x1, 0x2, 0x3, 0x4 with RRESP=OKAY, and regs_o=0x00000004_00000003_00000002_00000001.
- reg1 preset to 0xAABBCCDD, then a write of 0x11223344 with WSTRB=4'b0101 → readback 0xAA22CC44 and wr_pulse_o=4'b0010 for one cycle.
- WVALID presented 3 cycles before AWVALID (address 0x8, data 0xDEADBEEF) → WREADY drops after the W handshake; BVALID comes 1 cycle after the AW handshake; reg2=0xDEADBEEF.
- BREADY and RREADY held low for 5 cycles → BVALID/RVALID, BRESP/RRESP and RDATA stay stable; AWREADY and ARREADY stay 0 until the response handshake.
- Write to 0x14 and read from 0x18 → SLVERR with the macro and OKAY without; RDATA=0; regs_o unchanged.
- ARESETN pulsed low in W_WAITD after an AW to 0x0 → BVALID=0, regs_o=0; the next full write to 0x0 completes normally.

Source files
------------

// File: rtl/cenzor_axil_pkg.sv
// Shared constants and types for the Cenzor AXI4-Lite register block.
// Build option CENZOR_AXIL_SLVERR_EN: unmapped word slots answer SLVERR instead of OKAY.
package cenzor_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef CENZOR_AXIL_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = RESP_SLVERR;
`else
  localparam logic [1:0] RESP_UNMAPPED = RESP_OKAY;
`endif

  localparam int unsigned NUM_REGS  = 4;
  localparam int unsigned REG_IDX_W = 2;

  localparam int unsigned REG_CTRL = 0;
  localparam int unsigned REG_CFG  = 1;
  localparam int unsigned REG_WORD = 2;
  localparam int unsigned REG_STAT = 3;

  typedef enum logic [1:0] {W_IDLE, W_WAITD, W_WAITA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_RESP} rd_state_t;

  function automatic logic [1:0] slot_resp(input logic mapped);
    return mapped ? RESP_OKAY : RESP_UNMAPPED;
  endfunction

endpackage

// File: rtl/cenzor_axil_wr_ch.sv
// AXI4-Lite write channel: AW/W handshakes in any order, latching whichever arrives first.
// Emits a one-cycle commit (wr_en/wr_idx/wr_data/wr_strb) into the register array.
module cenzor_axil_wr_ch
  import cenzor_axil_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IDX_W-1:0]     aw_idx,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [DW-1:0]        wdata,
  input  logic [DW/8-1:0]      wstrb,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  output logic                 wr_en,
  output logic [REG_IDX_W-1:0] wr_idx,
  output logic [DW-1:0]        wr_data,
  output logic [DW/8-1:0]      wr_strb
);

  wr_state_t        state_q, state_d;
  logic             ready_en;
  logic [IDX_W-1:0] idx_q, c_idx;
  logic [DW-1:0]    data_q;
  logic [DW/8-1:0]  strb_q;
  logic             commit, mapped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= W_IDLE;
      ready_en <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    awready = 1'b0;
    wready  = 1'b0;
    commit  = 1'b0;
    c_idx   = aw_idx;
    wr_data = wdata;
    wr_strb = wstrb;
    case (state_q)
      W_IDLE: begin
        awready = ready_en;
        wready  = ready_en;
        if (ready_en) begin
          if (awvalid && wvalid) begin
            commit  = 1'b1;
            state_d = W_RESP;
          end else if (awvalid) begin
            state_d = W_WAITD;
          end else if (wvalid) begin
            state_d = W_WAITA;
          end
        end
      end
      W_WAITD: begin
        wready = 1'b1;
        c_idx  = idx_q;
        if (wvalid) begin
          commit  = 1'b1;
          state_d = W_RESP;
        end
      end
      W_WAITA: begin
        awready = 1'b1;
        wr_data = data_q;
        wr_strb = strb_q;
        if (awvalid) begin
          commit  = 1'b1;
          state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  assign mapped = 32'(c_idx) < NUM_REGS;
  assign wr_en  = commit && mapped;
  assign wr_idx = c_idx[REG_IDX_W-1:0];
  assign bvalid = (state_q == W_RESP);

  // bresp is captured at the commit edge so it holds for the whole response phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      data_q <= '0;
      strb_q <= '0;
      bresp  <= RESP_OKAY;
    end else begin
      if (state_q == W_IDLE && ready_en) begin
        if (awvalid) idx_q <= aw_idx;
        if (wvalid) begin
          data_q <= wdata;
          strb_q <= wstrb;
        end
      end
      if (commit) bresp <= slot_resp(mapped);
    end
  end

endmodule

// File: rtl/cenzor_axil_regs.sv
// Cenzor S00_AXI register block: four 32-bit registers behind an AXI4-Lite responder.
// Optional CENZOR_AXIL_SLVERR_EN (see cenzor_axil_pkg) selects SLVERR for unmapped slots.
module cenzor_axil_regs
  import cenzor_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]                      AWPROT,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]                      ARPROT,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RVALID,
  input  logic                            RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]             wr_pulse_o
);

  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  logic [DW-1:0]        regs [NUM_REGS];
  logic                 wr_en;
  logic [REG_IDX_W-1:0] wr_idx;
  logic [DW-1:0]        wr_data;
  logic [DW/8-1:0]      wr_strb;

  logic unused_ok;
  assign unused_ok = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

  cenzor_axil_wr_ch #(
    .DW    (DW),
    .IDX_W (IDX_W)
  ) u_wr_ch (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .aw_idx  (AWADDR[C_S_AXI_ADDR_WIDTH-1:2]),
    .awvalid (AWVALID),
    .awready (AWREADY),
    .wdata   (WDATA),
    .wstrb   (WSTRB),
    .wvalid  (WVALID),
    .wready  (WREADY),
    .bresp   (BRESP),
    .bvalid  (BVALID),
    .bready  (BREADY),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (wr_en) begin
        wr_pulse_o[wr_idx] <= 1'b1;
        for (int unsigned k = 0; k < DW/8; k++) begin
          if (wr_strb[k]) regs[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  assign regs_o = {regs[REG_STAT], regs[REG_WORD], regs[REG_CFG], regs[REG_CTRL]};

  rd_state_t        rd_state_q, rd_state_d;
  logic             rd_ready_en;
  logic [IDX_W-1:0] ar_idx;
  logic             ar_mapped, ar_hs;

  assign ar_idx    = ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_mapped = 32'(ar_idx) < NUM_REGS;
  assign ar_hs     = ARVALID && ARREADY;
  assign RVALID    = (rd_state_q == R_RESP);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_q  <= R_IDLE;
      rd_ready_en <= 1'b0;
    end else begin
      rd_state_q  <= rd_state_d;
      rd_ready_en <= 1'b1;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    ARREADY    = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        ARREADY = rd_ready_en;
        if (ARVALID && rd_ready_en) rd_state_d = R_RESP;
      end
      R_RESP: begin
        if (RREADY) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // sampled before this edge's register update, so a colliding write reads back the old value
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      RDATA <= '0;
      RRESP <= RESP_OKAY;
    end else if (ar_hs) begin
      RDATA <= ar_mapped ? regs[ar_idx[REG_IDX_W-1:0]] : '0;
      RRESP <= slot_resp(ar_mapped);
    end
  end

endmodule
